// File: rtl/fxp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed fixed-point multiplier
// between NREQ requesters; saturated results return tagged with requester id.
module fxp_mul_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned QBITS = 16,
  parameter int unsigned LAT   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_mask,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_ovf,
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned PW  = 2 * WIDTH;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  elig_c;
  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   gnt_idx_c;
  logic             found_c;
  logic             acc_c;
  logic [WIDTH-1:0] a_sel_c, b_sel_c;
  logic [PW-1:0]    p_in_c;

  logic [LAT-1:0]   vld_q, vld_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             fin_vld_c;
  logic [IDW-1:0]   fin_id_c;
  logic [PW-1:0]    fin_p_c;
  logic signed [PW-1:0] r_c;
  logic [PW-WIDTH:0]    r_hi_c;

  assign elig_c = req_valid & req_mask;

  // First eligible index scanning from ptr upward, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    gnt_c     = '0;
    gnt_idx_c = '0;
    found_c   = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && elig_c[idx]) begin
        found_c   = 1'b1;
        gnt_idx_c = IDW'(idx);
      end
    end
    if (found_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  assign req_ready = gnt_c & {NREQ{rst_n}};
  assign acc_c     = found_c & rst_n;

  always_comb begin
    ptr_d = ptr_q;
    if (acc_c) begin
      if (32'(gnt_idx_c) == NREQ - 1) ptr_d = '0;
      else                            ptr_d = gnt_idx_c + IDW'(1);
    end
  end

  // Full-width signed product of the granted operands.
  assign a_sel_c = req_a[32'(gnt_idx_c) * WIDTH +: WIDTH];
  assign b_sel_c = req_b[32'(gnt_idx_c) * WIDTH +: WIDTH];
  assign p_in_c  = $signed({{WIDTH{a_sel_c[WIDTH-1]}}, a_sel_c})
                 * $signed({{WIDTH{b_sel_c[WIDTH-1]}}, b_sel_c});

  always_comb begin
    vld_d[0] = acc_c;
    for (int unsigned j = 1; j < LAT; j++) vld_d[j] = vld_q[j-1];
    busy_d = |vld_d;
  end

  // Intermediate stages hold the raw product; the output stage saturates.
  generate
    if (LAT > 1) begin : g_pipe
      logic [IDW-1:0] id_q [LAT-1];
      logic [IDW-1:0] id_d [LAT-1];
      logic [PW-1:0]  p_q  [LAT-1];
      logic [PW-1:0]  p_d  [LAT-1];

      always_comb begin
        id_d[0] = gnt_idx_c;
        p_d[0]  = p_in_c;
        for (int unsigned j = 1; j < LAT - 1; j++) begin
          id_d[j] = id_q[j-1];
          p_d[j]  = p_q[j-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned j = 0; j < LAT - 1; j++) begin
            id_q[j] <= '0;
            p_q[j]  <= '0;
          end
        end else begin
          id_q <= id_d;
          p_q  <= p_d;
        end
      end

      assign fin_vld_c = vld_q[LAT-2];
      assign fin_id_c  = id_q[LAT-2];
      assign fin_p_c   = p_q[LAT-2];
    end else begin : g_comb
      assign fin_vld_c = acc_c;
      assign fin_id_c  = gnt_idx_c;
      assign fin_p_c   = p_in_c;
    end
  endgenerate

  // Truncating rescale and saturation; outputs hold when no result lands.
  always_comb begin
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    r_c        = $signed(fin_p_c) >>> QBITS;
    r_hi_c     = r_c[PW-1:WIDTH-1];
    if (fin_vld_c) begin
      rsp_id_d = fin_id_c;
      if (&r_hi_c || ~|r_hi_c) begin
        rsp_data_d = r_c[WIDTH-1:0];
        rsp_ovf_d  = 1'b0;
      end else begin
        rsp_data_d = r_c[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        rsp_ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      vld_q      <= '0;
      busy_q     <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fxp_mul_arbiter.sv
// Directed bench for fxp_mul_arbiter (NREQ=4, WIDTH=32, QBITS=16, LAT=3).
module tb_fxp_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_mask;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ovf;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fxp_mul_arbiter #(.NREQ(4), .WIDTH(32), .QBITS(16), .LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated operation from requester id; result checked LAT cycles later.
  task automatic single_op(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_o, input string tag);
    req_valid = '0;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id] = 1'b1;
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << id));
    tick;
    req_valid = '0;
    chk({tag, "_busy1"}, 64'(busy), 64'(1));
    tick;
    chk({tag, "_early"}, 64'(rsp_valid), 64'(0));
    tick;
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
    chk({tag, "_ovf"}, 64'(rsp_ovf), 64'(exp_o));
    tick;
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_m [6];
    exp_m = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_mask  = 4'hF;
    req_a     = '0;
    req_b     = '0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_valid", 64'(rsp_valid), 64'(0));
    chk("rst_data", 64'(rsp_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    single_op(0, 32'h00018000, 32'h00020000, 32'h00030000, 1'b0, "mul_pos");
    single_op(1, 32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0, "mul_neg");
    single_op(2, 32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1, "sat_pos");
    single_op(3, 32'h80000000, 32'h00020000, 32'h80000000, 1'b1, "sat_neg");
    single_op(0, 32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFF, 1'b0, "trunc_neg");
    single_op(1, 32'h00000001, 32'h00008000, 32'h00000000, 1'b0, "trunc_pos");
    single_op(2, 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, "min_exact");
    single_op(3, 32'hFFFF0000, 32'hFFFF0000, 32'h00010000, 1'b0, "neg_sq");

    // Fairness: ptr is back at 0; requester i returns (i+1) * 1.0.
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'((i + 1) << 16);
      req_b[i*32 +: 32] = 32'h00010000;
    end
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      chk("fair_ready", 64'(req_ready), (c < 8) ? 64'(4'b0001 << (c % 4)) : 64'(0));
      if (c >= 3) begin
        chk("fair_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("fair_rsp_id", 64'(rsp_id), 64'((c - 3) % 4));
        chk("fair_rsp_data", 64'(rsp_data), 64'((((c - 3) % 4) + 1) << 16));
      end
      tick;
    end
    chk("fair_end", 64'(rsp_valid), 64'(0));

    // Masked requester 2 is skipped.
    req_mask  = 4'b1011;
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("mask_ready", 64'(req_ready), 64'(exp_m[c]));
      tick;
    end
    req_valid = '0;
    tick;
    tick;
    tick;
    chk("mask_drain_busy", 64'(busy), 64'(0));

    // In-flight op survives its requester being masked, then everything masked.
    req_mask  = 4'hF;
    req_valid = 4'b0100;
    #1;
    chk("inflight_ready", 64'(req_ready), 64'(4'b0100));
    tick;
    req_mask  = 4'h0;
    req_valid = 4'hF;
    #1;
    chk("allmask_ready0", 64'(req_ready), 64'(0));
    tick;
    chk("allmask_ready1", 64'(req_ready), 64'(0));
    tick;
    chk("inflight_valid", 64'(rsp_valid), 64'(1));
    chk("inflight_id", 64'(rsp_id), 64'(2));
    chk("inflight_data", 64'(rsp_data), 64'(32'h00030000));
    tick;
    chk("inflight_pulse", 64'(rsp_valid), 64'(0));
    chk("inflight_idle", 64'(busy), 64'(0));

    // Reset mid-flight: ptr=3, requesters 0 and 1 accepted, then reset.
    req_mask  = 4'hF;
    req_valid = 4'b0011;
    #1;
    chk("rst2_grant0", 64'(req_ready), 64'(4'b0001));
    tick;
    chk("rst2_grant1", 64'(req_ready), 64'(4'b0010));
    tick;
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", 64'(req_ready), 64'(0));
    chk("rst2_valid", 64'(rsp_valid), 64'(0));
    chk("rst2_id", 64'(rsp_id), 64'(0));
    chk("rst2_data", 64'(rsp_data), 64'(0));
    chk("rst2_ovf", 64'(rsp_ovf), 64'(0));
    chk("rst2_busy", 64'(busy), 64'(0));
    tick;
    tick;
    rst_n = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rst2_first_grant", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rst2_no_rsp", 64'(rsp_valid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
